// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 -> 32-bit unsigned shift-add multiplier.
// One add16 operation per RUN cycle, 16 iterations, data-independent latency.

// add16: 16-bit ripple-free behavioural adder with carry in/out.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Full 17-bit sum so the carry out is never lost
  assign {cout, sum} = 17'(a) + 17'(b) + 17'(cin);

endmodule

module mul16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   ph_q, ph_d;
  logic [WIDTH-1:0]   pl_q, pl_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // Partial-product addend: multiplicand when the current multiplier bit is set
  assign add_b = pl_q[0] ? m_q : '0;

  add16 u_add16 (
    .a    (ph_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    ph_d      = ph_q;
    pl_d      = pl_q;
    product_d = product_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = a;
          pl_d    = b;
          ph_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Carry enters PH msb, then the 33-bit {cout,sum,PL} shifts right by one
        ph_d  = {add_cout, add_sum[WIDTH-1:1]};
        pl_d  = {add_sum[0], pl_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          product_d = {ph_d, pl_d};
          ovf_d     = |ph_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      ph_q      <= '0;
      pl_q      <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      ph_q      <= ph_d;
      pl_q      <= pl_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed self-checking bench for mul16_seq.
module tb_mul16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int n_checks;
  int n_errors;

  mul16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and check latency, result, pulse width and hold
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic [31:0] exp_p, input logic exp_ovf);
    int lat;
    check_eq({tag, "_ready_pre"}, 32'(ready), 32'd1);
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();                       // accept edge k
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_ready_busy"}, 32'(ready), 32'd0);
    lat = 0;
    // cycle index n+1 after the accept edge; done expected in cycle 17
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n + 1;
        break;
      end
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd17);
    check_eq({tag, "_product"}, product, exp_p);
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    tick();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_ready_post"}, 32'(ready), 32'd1);
    check_eq({tag, "_hold"}, product, exp_p);
  endtask

  initial begin
    int          dones;
    int          done_at [3];
    logic [31:0] got_p [3];
    logic [15:0] ta, tb;
    logic [31:0] exp6 [3];

    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_product", product, 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    tick();

    // Directed vectors with hand-computed products
    run_op("t1_3x5",      16'h0003, 16'h0005, 32'h0000000F, 1'b0);
    run_op("t2_ffffsq",   16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run_op("t2_1234x5678",16'h1234, 16'h5678, 32'h06260060, 1'b1);
    run_op("t3_ffx101",   16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0);
    run_op("t3_zero",     16'h0000, 16'hABCD, 32'h00000000, 1'b0);

    // Start pulse during RUN must be ignored
    a = 16'h0007; b = 16'h0009; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    a = 16'h0002; b = 16'h0002; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) begin
        dones++;
        check_eq("t4_product", product, 32'h0000003F);
      end
    end
    check_eq("t4_done_count", 32'(dones), 32'd1);
    check_eq("t4_hold", product, 32'h0000003F);
    check_eq("t4_idle", 32'(ready), 32'd1);

    // Reset at iteration 8 aborts with no done
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();                       // accept edge k
    start = 1'b0;
    repeat (7) tick();            // edges k+1..k+7
    rst = 1'b1;
    tick();                       // edge k+8 sees reset
    rst = 1'b0;
    check_eq("t5_product", product, 32'h0);
    check_eq("t5_ovf", 32'(ovf), 32'd0);
    check_eq("t5_ready", 32'(ready), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (done) dones++;
    end
    check_eq("t5_no_done", 32'(dones), 32'd0);

    // Start held high 40 cycles with per-cycle operands; accepts at cycles 0, 18, 36
    for (int k = 0; k < 3; k++) begin
      ta = 16'h0100 + 16'(18 * k);
      tb = 16'h0030 + 16'(54 * k);
      exp6[k] = 32'(ta) * 32'(tb);
    end
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 40) begin
        start = 1'b1;
        a = 16'h0100 + 16'(i);
        b = 16'h0030 + 16'(3 * i);
      end else begin
        start = 1'b0;
      end
      tick();                     // edge i
      if (done) begin
        if (dones < 3) begin
          done_at[dones] = i;
          got_p[dones]   = product;
        end
        dones++;
      end
      if (i == 39) check_eq("t6_dones_in_window", 32'(dones), 32'd2);
    end
    check_eq("t6_total_dones", 32'(dones), 32'd3);
    if (dones >= 2) begin
      check_eq("t6_first_at", 32'(done_at[0]), 32'd16);
      check_eq("t6_spacing", 32'(done_at[1] - done_at[0]), 32'd18);
      check_eq("t6_p0", got_p[0], exp6[0]);
      check_eq("t6_p1", got_p[1], exp6[1]);
    end
    if (dones >= 3) check_eq("t6_p2", got_p[2], exp6[2]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
